// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared state encoding, width default and ALU flag layout for iter_divider
package iter_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Divider never produces carry or overflow, so C and V are always clear.
  function automatic logic [3:0] nz_flags(input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = 1'b0;
    f[FLAG_V] = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract step of the iterative divider
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);

  logic [WIDTH:0] partial;

  assign partial = {rem, msb};
  assign qbit    = (partial >= {1'b0, divisor});
  // When the subtract happens the difference is below the divisor, so it fits in WIDTH bits.
  assign next_rem = qbit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multicycle restoring divider, one quotient bit per clock; SIGNED_DIV_EN enables SDIV
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, state_n;
  logic            accept;
  logic            b_zero;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] dvd, dsr, rem, rem_n;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic            qbit;

  assign b_zero = (b == '0);
  assign busy   = (state == RUN) || (state == FIX);
  assign done   = (state == DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .msb      (dvd[WIDTH-1]),
    .divisor  (dsr),
    .next_rem (rem_n),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = b_zero ? DONE : RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN:     if (count == LAST) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

`ifdef SIGNED_DIV_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg = sign & a[WIDTH-1];
  assign b_neg = sign & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  // Truncating division: quotient sign is the xor, remainder follows the dividend.
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_sign;

  assign unused_sign = sign;
  assign a_mag = a;
  assign b_mag = b;
  assign q_fix = dvd;
  assign r_fix = rem;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      ALUFlags    <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= b_zero;
      if (b_zero) begin
        quotient  <= '0;
        remainder <= a;
        ALUFlags  <= nz_flags(1'b0, 1'b1);
      end else begin
        dvd   <= a_mag;
        dsr   <= b_mag;
        rem   <= '0;
        count <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          // Quotient bits shift into the low end as the dividend drains out the top.
          dvd   <= {dvd[WIDTH-2:0], qbit};
          rem   <= rem_n;
          count <= count + 1'b1;
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          ALUFlags  <= nz_flags(q_fix[WIDTH-1], q_fix == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - randomized self-checking bench for iter_divider against an arithmetic reference
module tb_iter_divider;

`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, sign;
  logic [31:0] a, b;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;
  logic [3:0]  ALUFlags;

  int checks = 0;
  int errors = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sign        (sign),
    .a           (a),
    .b           (b),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .ALUFlags    (ALUFlags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'd0;
      r = x;
    end else if (s && SIGNED_EN) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sx / sy;
        r = sx % sy;
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Pulses start for one sampling edge, then counts edges (sampling edge = 1) until done.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        output int lat, output logic saw_busy);
    @(negedge clk);
    a = ia; b = ib; sign = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    saw_busy = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, ALUFlags, busy, done, div_by_zero} !== 71'd0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h f=%b busy=%b done=%b dbz=%b, expected all zero",
               quotient, remainder, ALUFlags, busy, done, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic bz;
    run_op(32'd100, 32'd7, 1'b0, lat, bz);
    checks++;
    if (bz !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bz); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL basic_latency: got %0d expected 34", lat); end
    checks++;
    if ({quotient, remainder, ALUFlags, div_by_zero} !== {32'd14, 32'd2, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d f=%b dbz=%b, expected q=14 r=2 f=0000 dbz=0",
               quotient, remainder, ALUFlags, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, quotient} !== {1'b0, 1'b0, 32'd14}) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b q=%0d, expected done=0 busy=0 q=14",
               done, busy, quotient);
    end
  endtask

  task automatic test_div_zero();
    int lat; logic bz;
    run_op(32'd5, 32'd0, 1'b0, lat, bz);
    checks++;
    if (lat !== 1 || bz !== 1'b0) begin
      errors++;
      $display("FAIL dbz_latency: got lat=%0d busy=%b, expected lat=1 busy=0", lat, bz);
    end
    checks++;
    if ({quotient, remainder, ALUFlags, div_by_zero} !== {32'd0, 32'd5, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%h f=%b dbz=%b, expected q=0 r=5 f=0100 dbz=1",
               quotient, remainder, ALUFlags, div_by_zero);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: got %b expected 1", div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd1; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 9) begin
        checks++;
        if ({quotient, remainder, busy} !== {32'd0, 32'd5, 1'b1}) begin
          errors++;
          $display("FAIL run_output_hold: got q=%h r=%h busy=%b, expected q=0 r=5 busy=1",
                   quotient, remainder, busy);
        end
        a = 32'd3; b = 32'd3; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
    checks++;
    if ({quotient, remainder, ALUFlags, div_by_zero} !== {32'hFFFF_FFFF, 32'd0, 4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result: got q=%h r=%h f=%b dbz=%b, expected q=ffffffff r=0 f=1000 dbz=0",
               quotient, remainder, ALUFlags, div_by_zero);
    end
  endtask

  task automatic test_signed();
    int lat; logic bz;
    logic [31:0] eq, er;
    logic [31:0] xs [2];
    logic [31:0] ys [2];
    xs[0] = 32'hFFFF_FFF9; ys[0] = 32'd2;
    xs[1] = 32'h8000_0000; ys[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      run_op(xs[i], ys[i], 1'b1, lat, bz);
      model(xs[i], ys[i], 1'b1, eq, er);
      checks++;
      if ({quotient, remainder, lat} !== {eq, er, 32'd34}) begin
        errors++;
        $display("FAIL signed_%0d: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=34",
                 i, quotient, remainder, lat, eq, er);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic bz;
    @(negedge clk);
    a = 32'd100; b = 32'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({quotient, remainder, ALUFlags, busy, done, div_by_zero} !== 71'd0) begin
      errors++;
      $display("FAIL midrun_reset: got q=%h r=%h f=%b busy=%b done=%b dbz=%b, expected all zero",
               quotient, remainder, ALUFlags, busy, done, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd30, 32'd4, 1'b0, lat, bz);
    checks++;
    if ({quotient, remainder, lat} !== {32'd7, 32'd2, 32'd34}) begin
      errors++;
      $display("FAIL after_reset: got q=%0d r=%0d lat=%0d, expected q=7 r=2 lat=34",
               quotient, remainder, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic bz;
    run_op(32'd20, 32'd6, 1'b0, lat, bz);
    checks++;
    if ({quotient, remainder, done} !== {32'd3, 32'd2, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: got q=%0d r=%0d done=%b, expected q=3 r=2 done=1",
               quotient, remainder, done);
    end
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({quotient, remainder, lat} !== {32'd3, 32'd0, 32'd34}) begin
      errors++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d, expected q=3 r=0 lat=34",
               quotient, remainder, lat);
    end
  endtask

  task automatic test_random();
    int lat, elat; logic bz;
    logic [31:0] x, y, eq, er;
    logic s;
    for (int i = 0; i < 40; i++) begin
      x = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = $urandom;
        default: y = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      endcase
      s = $urandom_range(0, 1);
      run_op(x, y, s, lat, bz);
      model(x, y, s, eq, er);
      elat = (y == 32'd0) ? 1 : 34;
      checks++;
      if ({quotient, remainder, ALUFlags, div_by_zero} !== {eq, er, eq[31], eq == 32'd0, 2'b00, y == 32'd0}
          || lat !== elat) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h s=%b: got q=%h r=%h f=%b dbz=%b lat=%0d, expected q=%h r=%h f=%b dbz=%b lat=%0d",
                 i, x, y, s, quotient, remainder, ALUFlags, div_by_zero, lat,
                 eq, er, {eq[31], eq == 32'd0, 2'b00}, y == 32'd0, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_signed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
